// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, state encoding and decode helpers for the MEM-stage LSU
package mem_lsu_pkg;

   localparam logic [7:0] OP_LB  = 8'b11100000;
   localparam logic [7:0] OP_LH  = 8'b11100001;
   localparam logic [7:0] OP_LW  = 8'b11100011;
   localparam logic [7:0] OP_LBU = 8'b11100100;
   localparam logic [7:0] OP_LHU = 8'b11100101;
   localparam logic [7:0] OP_SB  = 8'b11101000;
   localparam logic [7:0] OP_SH  = 8'b11101001;
   localparam logic [7:0] OP_SW  = 8'b11101011;

   localparam logic        RstEnable = 1'b1;
   localparam logic        Stop      = 1'b1;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   function automatic logic is_mem_op(input logic [7:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
         default:                                                  is_mem_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input logic [7:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
         default:                             is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: is_misaligned = addr_lo[0];
         OP_LW, OP_SW:         is_misaligned = |addr_lo;
         default:              is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - big-endian byte-lane select, store replication and load extraction
module lsu_lane
   import mem_lsu_pkg::*;
(
   input  logic [7:0]  aluop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] reg2,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Offset 0 is the most significant byte lane.
   always_comb begin
      case (addr_lo)
         2'd0:    rd_byte = rdata[31:24];
         2'd1:    rd_byte = rdata[23:16];
         2'd2:    rd_byte = rdata[15:8];
         default: rd_byte = rdata[7:0];
      endcase
      rd_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      sel       = 4'b0000;
      wdata     = reg2;
      load_data = ZeroWord;
      case (aluop)
         OP_LB:  begin sel = 4'b1000 >> addr_lo;                 load_data = {{24{rd_byte[7]}}, rd_byte}; end
         OP_LBU: begin sel = 4'b1000 >> addr_lo;                 load_data = {24'h0, rd_byte}; end
         OP_LH:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100;     load_data = {{16{rd_half[15]}}, rd_half}; end
         OP_LHU: begin sel = addr_lo[1] ? 4'b0011 : 4'b1100;     load_data = {16'h0, rd_half}; end
         OP_LW:  begin sel = 4'b1111;                            load_data = rdata; end
         OP_SB:  begin sel = 4'b1000 >> addr_lo;                 wdata = {4{reg2[7:0]}}; end
         OP_SH:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100;     wdata = {2{reg2[15:0]}}; end
         OP_SW:  begin sel = 4'b1111;                            wdata = reg2; end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit running one req/ack bus transaction at a time
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   input  logic [5:0]  stall,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stallreq,
   output logic        adr_err,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   lsu_state_e    state, state_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    op_q;
   logic [31:0]   load_q;
   logic          abort_q;
   logic          bus_err_q;

   logic [7:0]    lane_op;
   logic [1:0]    lane_addr;
   logic [3:0]    lane_sel;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_load;

   logic          mem_op;
   logic          misaligned;
   logic          start;
   logic          timeout_hit;
   logic          unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};

   assign mem_op      = is_mem_op(aluop_i);
   assign misaligned  = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);
   assign start       = (state == ST_IDLE) && mem_op && !misaligned;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

   // Lanes are decoded from the live inputs when launching, from the latched op afterwards.
   assign lane_op   = (state == ST_IDLE) ? aluop_i : op_q;
   assign lane_addr = (state == ST_IDLE) ? mem_addr_i[1:0] : bus_addr[1:0];

   lsu_lane u_lane (
      .aluop     (lane_op),
      .addr_lo   (lane_addr),
      .reg2      (reg2_i),
      .rdata     (bus_rdata),
      .sel       (lane_sel),
      .wdata     (lane_wdata),
      .load_data (lane_load)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) state <= ST_IDLE;
      else                  state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)                  state_nxt = ST_REQ;
         ST_REQ:  if (bus_ack || timeout_hit) state_nxt = ST_DONE;
         ST_DONE: if (stall[4] != Stop)       state_nxt = ST_IDLE;
         default:                             state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= ZeroWord;
         bus_sel   <= 4'b0000;
         bus_wdata <= ZeroWord;
         op_q      <= 8'h00;
         load_q    <= ZeroWord;
         abort_q   <= 1'b0;
         bus_err_q <= 1'b0;
         cnt       <= '0;
      end else begin
         bus_err_q <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               bus_req   <= 1'b1;
               bus_we    <= !is_load(aluop_i);
               bus_addr  <= mem_addr_i;
               bus_sel   <= lane_sel;
               bus_wdata <= lane_wdata;
               op_q      <= aluop_i;
               abort_q   <= 1'b0;
               cnt       <= '0;
            end
            ST_REQ: begin
               cnt <= cnt + CW'(1);
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  load_q  <= lane_load;
               end else if (timeout_hit) begin
                  bus_req   <= 1'b0;
                  abort_q   <= 1'b1;
                  bus_err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wd_o     = 5'd0;
      wreg_o   = 1'b0;
      wdata_o  = ZeroWord;
      stallreq = 1'b0;
      adr_err  = 1'b0;
      if (rst != RstEnable) begin
         case (state)
            ST_IDLE: begin
               wd_o    = wd_i;
               wdata_o = wdata_i;
               if (!mem_op)         wreg_o   = wreg_i;
               else if (misaligned) adr_err  = 1'b1;
               else                 stallreq = 1'b1;
            end
            ST_REQ: begin
               wd_o     = wd_i;
               wdata_o  = wdata_i;
               stallreq = 1'b1;
            end
            ST_DONE: begin
               wd_o = wd_i;
               if (is_load(op_q)) begin
                  wreg_o  = wreg_i && !abort_q;
                  wdata_o = load_q;
               end else begin
                  wdata_o = wdata_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_err = bus_err_q;

endmodule
